// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  // True for DIV/DIVU.
  function automatic logic op_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two's-complement variants (MULT/DIV).
  function automatic logic op_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/result bundle between pipeline control and the
// multiply/divide sequencer. master = pipeline side, slave = sequencer.
interface muldiv_if #(
  parameter int XLEN = muldiv_pkg::XLEN
) ();
  import muldiv_pkg::*;

  logic            start;
  md_op_t          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;

  modport master (
    output start, op, a, b, flush, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, flush, mthi, mtlo,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath on the {acc, q} working pair.
// Multiply: conditional add of the multiplicand into acc, then shift the pair
//   right; after XLEN steps {acc, q} is the 2*XLEN product.
// Divide: shift the pair left, trial-subtract the divisor from acc and keep the
//   difference when it does not go negative; after XLEN steps q is the quotient
//   and acc the remainder (restoring division on magnitudes).
module muldiv_step #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] addend;

  // Select and evaluate the multiply or divide step for this cycle.
  always_comb begin
    acc_next = acc;
    q_next   = q;
    sum      = '0;
    shifted  = '0;
    addend   = '0;
    if (is_div) begin
      // acc is always below the divisor, so the shifted partial remainder
      // fits in XLEN+1 bits and the kept difference fits back into XLEN.
      shifted = {acc, q[XLEN-1]};
      if (shifted >= {1'b0, operand}) begin
        acc_next = shifted[XLEN-1:0] - operand;
        q_next   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new top bit of acc after the shift.
      addend   = q[0] ? operand : '0;
      sum      = {1'b0, acc} + {1'b0, addend};
      acc_next = sum[XLEN:1];
      q_next   = {sum[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO pair. One datapath
// step per cycle over XLEN cycles, then a sign-fix cycle that writes HI/LO
// and pulses done. busy stays high from launch until the fix cycle retires.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  md_state_t       state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] operand;
  logic            op_div;
  logic            sign_diff;   // signed op with operands of opposite sign
  logic            a_neg;       // signed op with a negative dividend
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            done;

  logic            in_div;
  logic            in_signed;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] q_next;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Operands are reduced to magnitudes so one unsigned datapath serves all ops.
  assign in_div    = op_is_div(bus.op);
  assign in_signed = op_is_signed(bus.op);
  assign a_mag     = (in_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign b_mag     = (in_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_div),
    .acc      (acc),
    .q        (q),
    .operand  (operand),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Sign correction applied in the FIX cycle. A zero divisor leaves the
  // quotient as all-ones and the corrected remainder equal to the dividend.
  assign prod     = {acc, q};
  assign prod_fix = sign_diff ? -prod : prod;
  assign quo_fix  = (sign_diff && !div_zero) ? -q : q;
  assign rem_fix  = a_neg ? -acc : acc;

  // Sequencer FSM, iteration counter, operand latches, HI/LO and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      q         <= '0;
      operand   <= '0;
      op_div    <= 1'b0;
      sign_diff <= 1'b0;
      a_neg     <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Moves to HI/LO only land while idle; a same-cycle start later
      // overwrites both registers when it retires.
      if (state == IDLE) begin
        if (bus.mthi) hi <= bus.a;
        if (bus.mtlo) lo <= bus.a;
      end
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state     <= CALC;
              count     <= CNT_W'(XLEN - 1);
              acc       <= '0;
              q         <= in_div ? a_mag : b_mag;
              operand   <= in_div ? b_mag : a_mag;
              op_div    <= in_div;
              sign_diff <= in_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
              a_neg     <= in_signed && bus.a[XLEN-1];
              div_zero  <= (bus.b == '0);
            end
          end
          CALC: begin
            acc   <= acc_next;
            q     <= q_next;
            count <= count - 1'b1;
            if (count == '0) state <= FIX;
          end
          FIX: begin
            if (op_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.hi   = hi;
  assign bus.lo   = lo;
  assign bus.busy = (state != IDLE);
  assign bus.done = done;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: drivers push expected {HI,LO} from a plain
// arithmetic reference model; a monitor pops and compares on every done pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  int run_len  = 0;
  int last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic logic [63:0] ref_model(md_op_t op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, qq, rr;
    logic [63:0] r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = '0;
    case (op)
      MD_MULT:  r = 64'(sa * sb);
      MD_MULTU: r = 64'(ua * ub);
      MD_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          qq = sa / sb;
          rr = sa % sb;
          r  = {32'(rr), 32'(qq)};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          qq = ua / ub;
          rr = ua % ub;
          r  = {32'(rr), 32'(qq)};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 11))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: track busy run length and score each done pulse.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.busy) run_len++;
      else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (bus.done === 1'b1) begin
        check("done_not_busy", 32'(bus.busy), 32'd0);
        check("latency", 32'(last_run), 32'd33);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          e = exp_q.pop_front();
          check("hi", bus.hi, e[63:32]);
          check("lo", bus.lo, e[31:0]);
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
  endtask

  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    exp_q.push_back(ref_model(op, a, b));
    $display("op=%0d a=%08h b=%08h", op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    issue(MD_MULT,  32'd7,        32'hFFFF_FFFD);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(MD_DIVU,  32'd100,      32'd7);
    issue(MD_DIVU,  32'd100,      32'd0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd0);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    drain();

    // Preload HI/LO, then abort a multiply with flush.
    bus.a = 32'hAA; bus.mthi = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0; bus.a = 32'h55; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mthi_idle", bus.hi, 32'hAA);
    check("mtlo_idle", bus.lo, 32'h55);
    bus.op = MD_MULT; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", bus.hi, 32'hAA);
    check("flush_lo", bus.lo, 32'h55);

    // Flush and start together: nothing launches.
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);

    // mthi while busy is ignored.
    issue(MD_MULTU, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    bus.a = 32'h1234; bus.mthi = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_busy", bus.hi, 32'hAA);
    drain();

    // mthi coinciding with start writes now, result overwrites later.
    bus.mthi = 1'b1;
    issue(MD_MULT, 32'd9, 32'd9);
    bus.mthi = 1'b0;
    check("mthi_with_start", bus.hi, 32'd9);
    drain();

    // Asynchronous reset mid-divide.
    bus.op = MD_DIV; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_hi", bus.hi, 32'h0);
    check("arst_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(MD_DIVU, 32'd1000, 32'd7);
    drain();

    // Randomized mix against the reference model.
    for (int i = 0; i < 40; i++) begin
      md_op_t rop;
      rop = md_op_t'($urandom_range(0, 3));
      issue(rop, pick(), pick());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
